// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and bit-timing helper
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_RECOVER} state_t;
  function automatic int cycles_per_bit(int clk_mhz, int baud);
    return clk_mhz * 1000000 / baud;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte valid/ready channel plus error pulses
interface uart_rx_if;
  logic [7:0] data;
  logic valid;
  logic ready;
  logic frame_err;
  logic overrun;
  modport master(output data, valid, frame_err, overrun, input ready);
  modport slave(input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input
module uart_sync2 #(parameter logic RST_VAL = 1'b1) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with single-entry output register
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ = 27,
  parameter int BAUD = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  uart_rx_if.master bus
);
  localparam int CYCLE = cycles_per_bit(CLK_FREQ, BAUD);
  localparam int HALF = CYCLE / 2;
  state_t state;
  logic rx_s;
  logic [15:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift, data;
  logic valid, frame_err, overrun;
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  assign bus.data = data;
  assign bus.valid = valid;
  assign bus.frame_err = frame_err;
  assign bus.overrun = overrun;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun <= 1'b0;
      if (valid && bus.ready) valid <= 1'b0;
      case (state)
        S_IDLE: if (!rx_s) begin
          state <= S_START;
          cnt <= '0;
        end
        S_START: if (cnt == 16'(HALF - 1)) begin
          cnt <= '0;
          bit_cnt <= '0;
          state <= rx_s ? S_IDLE : S_DATA;
        end else cnt <= cnt + 16'd1;
        S_DATA: if (cnt == 16'(CYCLE - 1)) begin
          cnt <= '0;
          shift[bit_cnt] <= rx_s;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= S_STOP;
        end else cnt <= cnt + 16'd1;
        S_STOP: if (cnt == 16'(CYCLE - 1)) begin
          cnt <= '0;
          state <= rx_s ? S_IDLE : S_RECOVER;
          frame_err <= !rx_s;
          // a full register that is not draining this cycle keeps its byte
          if (rx_s && (!valid || bus.ready)) begin
            data <= shift;
            valid <= 1'b1;
          end
          overrun <= rx_s && valid && !bus.ready;
        end else cnt <= cnt + 16'd1;
        S_RECOVER: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a byte-level model
module tb_uart_rx;
  import uart_pkg::*;
  localparam int CYC = 234;
  localparam int LAT = 2 + 117 + 9 * 234;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  uart_rx_if bus();
  uart_rx dut (.clk(clk), .rst(rst), .rx(rx), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int cyc = 0;
  logic [7:0] got_q[$], exp_q[$];
  int ferr_n = 0, ovr_n = 0, ferr_exp = 0, ovr_exp = 0, unstable = 0;
  int rise_cyc = -1;
  bit held = 0;
  logic pv = 1'b0, pc = 1'b0;
  logic [7:0] pd = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.valid && bus.ready) got_q.push_back(bus.data);
    if (bus.frame_err) ferr_n++;
    if (bus.overrun) ovr_n++;
    if (bus.valid && !pv && rise_cyc < 0) rise_cyc = cyc;
    if (bus.valid && pv && !pc && bus.data != pd) unstable++;
    pv = bus.valid;
    pc = bus.valid && bus.ready;
    pd = bus.data;
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Drives one frame of period p and records the outcome the link rules predict.
  task automatic send(input logic [7:0] b, input int p, input bit stop);
    rx = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(p);
    end
    rx = stop;
    tick(p);
    if (!stop) ferr_exp++;
    else if (!held || bus.ready) begin
      exp_q.push_back(b);
      held = !bus.ready;
    end else ovr_exp++;
  endtask
  task automatic flush(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
    chk({tag, "_frame_err"}, ferr_n, ferr_exp);
    chk({tag, "_overrun"}, ovr_n, ovr_exp);
    chk({tag, "_stable"}, unstable, 0);
    got_q.delete();
    exp_q.delete();
    ferr_n = 0; ovr_n = 0; ferr_exp = 0; ovr_exp = 0; unstable = 0;
  endtask
  initial begin
    int fall, lat;
    logic [7:0] b;
    bus.ready = 1'b1;
    tick(3);
    chk("rst_data", int'(bus.data), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    tick(10);
    rise_cyc = -1;
    fall = cyc;
    send(8'hA5, CYC, 1'b1);
    lat = rise_cyc - fall;
    chk($sformatf("latency_%0d_in_window", lat), int'(lat >= LAT - 1 && lat <= LAT + 1), 1);
    tick(20);
    flush("a5");
    rx = 1'b0;
    tick(50);
    rx = 1'b1;
    tick(400);
    chk("glitch_idle", int'(dut.state), int'(S_IDLE));
    flush("glitch");
    send(8'h3C, CYC, 1'b1);
    tick(20);
    flush("after_glitch");
    send(8'h3C, CYC, 1'b0);
    tick(20 * CYC);
    rx = 1'b1;
    tick(50);
    flush("break");
    send(8'h11, CYC, 1'b1);
    tick(20);
    flush("after_break");
    bus.ready = 1'b0;
    send(8'h01, CYC, 1'b1);
    send(8'h02, CYC, 1'b1);
    tick(20);
    chk("held_valid", int'(bus.valid), 1);
    chk("held_data", int'(bus.data), 8'h01);
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    held = 0;
    @(negedge clk);
    chk("drained_valid", int'(bus.valid), 0);
    chk("drained_data", int'(bus.data), 8'h01);
    tick(1);
    flush("overrun");
    bus.ready = 1'b1;
    send(8'h00, CYC, 1'b1);
    send(8'hFF, CYC, 1'b1);
    send(8'h55, CYC, 1'b1);
    tick(20);
    flush("b2b");
    send(8'h96, 227, 1'b1);
    tick(10);
    send(8'h96, 241, 1'b1);
    tick(20);
    flush("skew");
    bus.ready = 1'b0;
    send(8'h77, CYC, 1'b1);
    tick(20);
    chk("pre_rst_valid", int'(bus.valid), 1);
    b = 8'hC3;
    rx = 1'b0;
    tick(CYC);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(CYC);
    end
    rx = b[4];
    tick(CYC / 2);
    rst = 1'b1;
    #1;
    chk("midrst_data", int'(bus.data), 0);
    chk("midrst_valid", int'(bus.valid), 0);
    chk("midrst_frame_err", int'(bus.frame_err), 0);
    chk("midrst_overrun", int'(bus.overrun), 0);
    void'(exp_q.pop_back());
    held = 0;
    rx = 1'b1;
    bus.ready = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(50);
    send(8'h5A, CYC, 1'b1);
    tick(20);
    flush("reset");
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom), $urandom_range(227, 241), 1'b1);
      tick($urandom_range(0, 20));
    end
    tick(20);
    flush("random");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout got %0d exp %0d", cyc, 0);
    $fatal(1);
  end
endmodule
